// File: rtl/psum_ofifo.sv
// Output collection FIFO for the MAC column array: one circular lane per column
// absorbs skewed partial sums, and a full row pops atomically into a registered wide word.
module psum_ofifo #(
  parameter int col     = 8,
  parameter int bw_psum = 22,
  parameter int depth   = 16,
  parameter int aw      = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*bw_psum-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*bw_psum-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);

  // Handshake: a row pops at an edge where rd && o_valid; rd without o_valid is ignored.
  // Pushes are not backpressured here; upstream must stall issue while o_ready is low,
  // otherwise a push into a full lane is dropped and overflow latches.

  localparam logic [aw:0] ptr_one = (aw+1)'(1);

  logic [bw_psum-1:0] mem [col][depth];
  logic [aw:0]        wr_ptr [col];
  logic [aw:0]        rd_ptr [col];
  logic [col-1:0]     empty;
  logic [col-1:0]     full;
  logic [col-1:0]     push;
  logic [col-1:0]     drop;
  logic               rd_en;

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < col; i++) begin
      empty[i] = (wr_ptr[i] == rd_ptr[i]);
      full[i]  = (wr_ptr[i][aw-1:0] == rd_ptr[i][aw-1:0]) &&
                 (wr_ptr[i][aw] != rd_ptr[i][aw]);
    end
  end

  assign o_valid = &(~empty);
  assign o_full  = |full;
  assign o_ready = ~o_full;
  assign rd_en   = rd & o_valid;

  // A full lane still accepts a push when the same edge pops a row, freeing its head.
  assign push = wr & (~full | {col{rd_en}});
  assign drop = wr & full & {col{~rd_en}};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < col; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      for (int i = 0; i < col; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + ptr_one;
        if (rd_en) begin
          rd_ptr[i]                  <= rd_ptr[i] + ptr_one;
          out[i*bw_psum +: bw_psum]  <= mem[i][rd_ptr[i][aw-1:0]];
        end
      end
      if (|drop) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < col; i++) begin
      if (push[i]) mem[i][wr_ptr[i][aw-1:0]] <= in[i*bw_psum +: bw_psum];
    end
  end

endmodule

// File: tb/tb_psum_ofifo.sv
// Directed bench for psum_ofifo: reset, aligned and skewed rows, fill/overflow,
// pop+push on full lanes, and signed data across pointer wrap.
module tb_psum_ofifo;

  localparam int COL   = 8;
  localparam int BW    = 22;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic              clk;
  logic              reset;
  logic [COL*BW-1:0] in;
  logic [COL-1:0]    wr;
  logic              rd;
  logic [COL*BW-1:0] out;
  logic              o_valid;
  logic              o_full;
  logic              o_ready;
  logic              overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [COL*BW-1:0] exp_row;
  logic [COL*BW-1:0] last_row;

  psum_ofifo #(.col(COL), .bw_psum(BW), .depth(DEPTH), .aw(AW)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [COL*BW-1:0] all_row(input logic [BW-1:0] v);
    logic [COL*BW-1:0] r;
    for (int i = 0; i < COL; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  task automatic reset_dut;
    reset = 1'b1; wr = '0; rd = 1'b0;
    tick();
    reset = 1'b0;
    total_cnt++;
    if (o_valid !== 1'b0 || o_full !== 1'b0 || overflow !== 1'b0)
      $display("FAIL mid_reset: valid=%b full=%b ovf=%b required 0 0 0", o_valid, o_full, overflow);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    for (int c = 0; c < 2; c++) begin
      wr = COL'($urandom_range(0, 255));
      rd = 1'($urandom_range(0, 1));
      for (int i = 0; i < COL; i++) in[i*BW +: BW] = BW'($urandom_range(0, 4000000));
      tick();
    end
    reset = 1'b0; wr = '0; rd = 1'b0;
    total_cnt++;
    if (out !== '0) $display("FAIL reset_out: got %h required 0", out); else pass_cnt++;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b required 0", o_valid); else pass_cnt++;
    total_cnt++;
    if (o_full !== 1'b0) $display("FAIL reset_full: got %b required 0", o_full); else pass_cnt++;
    total_cnt++;
    if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b required 1", o_ready); else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b required 0", overflow); else pass_cnt++;
  endtask

  task automatic test_aligned;
    for (int i = 0; i < COL; i++) begin
      in[i*BW +: BW]      = BW'(100 + i);
      exp_row[i*BW +: BW] = BW'(100 + i);
    end
    wr = 8'hFF;
    tick();
    wr = '0;
    total_cnt++;
    if (o_valid !== 1'b1) $display("FAIL aligned_valid: got %b required 1", o_valid); else pass_cnt++;
    rd = 1'b1;
    tick();
    rd = 1'b0;
    total_cnt++;
    if (out !== exp_row) $display("FAIL aligned_out: got %h required %h", out, exp_row); else pass_cnt++;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL aligned_valid_after: got %b required 0", o_valid); else pass_cnt++;
    last_row = exp_row;
  endtask

  task automatic test_skewed;
    logic exp_v;
    for (int i = 0; i < COL; i++) begin
      in = '0;
      in[i*BW +: BW]      = BW'(10 * i);
      exp_row[i*BW +: BW] = BW'(10 * i);
      wr = COL'(1) << i;
      rd = (i == 4);
      tick();
      wr = '0; rd = 1'b0;
      exp_v = (i == COL - 1);
      total_cnt++;
      if (o_valid !== exp_v)
        $display("FAIL skew_valid[%0d]: got %b required %b", i, o_valid, exp_v);
      else pass_cnt++;
      if (i == 4) begin
        total_cnt++;
        if (out !== last_row) $display("FAIL skew_ignored_rd: got %h required %h", out, last_row);
        else pass_cnt++;
      end
    end
    rd = 1'b1;
    tick();
    rd = 1'b0;
    total_cnt++;
    if (out !== exp_row) $display("FAIL skew_out: got %h required %h", out, exp_row); else pass_cnt++;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL skew_valid_after: got %b required 0", o_valid); else pass_cnt++;
  endtask

  task automatic test_fill_overflow;
    for (int k = 0; k < DEPTH; k++) begin
      in = all_row(BW'(k));
      wr = 8'hFF;
      tick();
    end
    wr = '0;
    total_cnt++;
    if (o_full !== 1'b1 || o_ready !== 1'b0)
      $display("FAIL fill_full: full=%b ready=%b required 1 0", o_full, o_ready);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL fill_no_ovf: got %b required 0", overflow); else pass_cnt++;
    in = all_row(BW'(99));
    wr = 8'hFF;
    tick();
    wr = '0;
    total_cnt++;
    if (overflow !== 1'b1) $display("FAIL fill_ovf: got %b required 1", overflow); else pass_cnt++;
    for (int k = 0; k < DEPTH; k++) begin
      rd = 1'b1;
      tick();
      exp_row = all_row(BW'(k));
      total_cnt++;
      if (out !== exp_row) $display("FAIL fill_pop[%0d]: got %h required %h", k, out, exp_row);
      else pass_cnt++;
    end
    rd = 1'b0;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL fill_drained: got %b required 0", o_valid); else pass_cnt++;
  endtask

  task automatic test_full_rdwr;
    reset_dut();
    for (int k = 0; k < DEPTH; k++) begin
      in = all_row(BW'(200 + k));
      wr = 8'hFF;
      tick();
    end
    in = all_row(BW'(77));
    wr = 8'hFF;
    rd = 1'b1;
    tick();
    wr = '0; rd = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL rdwr_ovf: got %b required 0", overflow); else pass_cnt++;
    total_cnt++;
    if (o_full !== 1'b1) $display("FAIL rdwr_full: got %b required 1", o_full); else pass_cnt++;
    exp_row = all_row(BW'(200));
    total_cnt++;
    if (out !== exp_row) $display("FAIL rdwr_head: got %h required %h", out, exp_row); else pass_cnt++;
    for (int k = 1; k <= DEPTH; k++) begin
      rd = 1'b1;
      tick();
      exp_row = (k == DEPTH) ? all_row(BW'(77)) : all_row(BW'(200 + k));
      total_cnt++;
      if (out !== exp_row) $display("FAIL rdwr_pop[%0d]: got %h required %h", k, out, exp_row);
      else pass_cnt++;
    end
    rd = 1'b0;
  endtask

  task automatic test_signed_wrap;
    logic [BW-1:0] neg5;
    logic [BW-1:0] maxp;
    neg5 = 22'h3FFFFB;
    maxp = 22'h1FFFFF;
    reset_dut();
    for (int k = 0; k <= 40; k++) begin
      if (k < 40) begin
        for (int i = 0; i < COL; i++) in[i*BW +: BW] = ((k + i) % 2 == 0) ? neg5 : maxp;
        wr = 8'hFF;
      end else wr = '0;
      rd = (k > 0);
      tick();
      if (k > 0) begin
        for (int i = 0; i < COL; i++) exp_row[i*BW +: BW] = ((k - 1 + i) % 2 == 0) ? neg5 : maxp;
        total_cnt++;
        if (out !== exp_row) $display("FAIL signed_pop[%0d]: got %h required %h", k - 1, out, exp_row);
        else pass_cnt++;
      end
    end
    wr = '0; rd = 1'b0;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL signed_ovf: got %b required 0", overflow); else pass_cnt++;
    total_cnt++;
    if (o_valid !== 1'b0) $display("FAIL signed_drained: got %b required 0", o_valid); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1; wr = '0; rd = 1'b0; in = '0;
    exp_row = '0; last_row = '0;
    test_reset();
    test_aligned();
    test_skewed();
    test_fill_overflow();
    test_full_rdwr();
    test_signed_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
